// File: rtl/fp_pkg.sv
// Shared constants, state encoding and result packing for the FP add/normalize stage.
package fp_pkg;

  localparam int EXP_W_DEF  = 8;
  localparam int MANT_W_DEF = 24;
  localparam int FP_BIAS    = 127;
  localparam int INF_EXP    = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [31:0] pack_fp(input logic s, input logic [7:0] e, input logic [22:0] m);
    return {s, e, m};
  endfunction

endpackage

// File: rtl/fp_add_normalize_if.sv
// Operand/result bundle between the alignment stage, this block and its consumer.
interface fp_add_normalize_if
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
);
  // Both sides use valid/ready: a transfer happens on a rising clock edge where
  // valid and ready are both 1; the sender holds its payload until then.
  logic              inValid;
  logic              inReady;
  logic              signA;
  logic              signB;
  logic [EXP_W-1:0]  exponentIn;
  logic [MANT_W-1:0] alignedMantissaA;
  logic [MANT_W-1:0] alignedMantissaB;
  logic              outValid;
  logic              outReady;
  logic [31:0]       result;

  modport master (
    output inValid, signA, signB, exponentIn, alignedMantissaA, alignedMantissaB, outReady,
    input  inReady, outValid, result
  );

  modport slave (
    input  inValid, signA, signB, exponentIn, alignedMantissaA, alignedMantissaB, outReady,
    output inReady, outValid, result
  );
endinterface

// File: rtl/fp_lzc.sv
// Leading-zero count of a 24-bit mantissa; an all-zero input reports 24.
module fp_lzc (
  input  logic [23:0] val_i,
  output logic [4:0]  count_o
);
  always_comb begin
    count_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (val_i[i]) count_o = 5'(23 - i);
    end
  end
endmodule

// File: rtl/fp_add_normalize.sv
// Signed add of aligned mantissas, then normalize and pack to IEEE-754 single (truncating).
// FAST_NORM_EN: normalize left in a single cycle via fp_lzc instead of one bit per cycle.
module fp_add_normalize
  import fp_pkg::*;
#(
  parameter int EXP_W  = EXP_W_DEF,
  parameter int MANT_W = MANT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  fp_add_normalize_if.slave  bus,
  output state_t             dbg_state_o
);
  state_t            state_q, state_d;
  logic              sa_q, sa_d, sb_q, sb_d, sign_q, sign_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [MANT_W-1:0] a_q, a_d, b_q, b_d;
  logic [MANT_W:0]   sum_q, sum_d;
  logic [31:0]       result_q, result_d;
  logic [EXP_W-1:0]  exp_inc, exp_dec;

  assign exp_inc = exp_q + EXP_W'(1);
  assign exp_dec = exp_q - EXP_W'(1);

`ifdef FAST_NORM_EN
  logic [4:0]        lzc_cnt;
  logic [MANT_W:0]   sum_fast;
  logic [EXP_W-1:0]  exp_fast;

  fp_lzc u_lzc (.val_i(sum_q[MANT_W-1:0]), .count_o(lzc_cnt));
  assign sum_fast = sum_q << lzc_cnt;
  assign exp_fast = exp_q - EXP_W'(lzc_cnt);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.inValid) begin
          sa_d    = bus.signA;
          sb_d    = bus.signB;
          exp_d   = bus.exponentIn;
          a_d     = bus.alignedMantissaA;
          b_d     = bus.alignedMantissaB;
          state_d = ADD;
        end
      end
      ADD: begin
        state_d = NORM;
        if (sa_q == sb_q) begin
          sum_d  = {1'b0, a_q} + {1'b0, b_q};
          sign_d = sa_q;
        end else if (a_q > b_q) begin
          sum_d  = {1'b0, a_q - b_q};
          sign_d = sa_q;
        end else if (b_q > a_q) begin
          sum_d  = {1'b0, b_q - a_q};
          sign_d = sb_q;
        end else begin
          // Exact cancellation is always +0, independent of operand signs.
          sum_d    = '0;
          sign_d   = 1'b0;
          result_d = '0;
          state_d  = DONE;
        end
      end
      NORM: begin
        if (sum_q[MANT_W]) begin
          sum_d   = sum_q >> 1;
          exp_d   = exp_inc;
          state_d = DONE;
          if (exp_inc == EXP_W'(INF_EXP)) result_d = pack_fp(sign_q, 8'(INF_EXP), 23'd0);
          else                            result_d = pack_fp(sign_q, exp_inc[7:0], sum_q[MANT_W-1 -: 23]);
        end else if (sum_q[MANT_W-1]) begin
          result_d = pack_fp(sign_q, exp_q[7:0], sum_q[MANT_W-2 -: 23]);
          state_d  = DONE;
        end else begin
`ifdef FAST_NORM_EN
          state_d = DONE;
          if (EXP_W'(lzc_cnt) >= exp_q) begin
            sum_d    = '0;
            exp_d    = '0;
            result_d = pack_fp(sign_q, 8'd0, 23'd0);
          end else begin
            sum_d    = sum_fast;
            exp_d    = exp_fast;
            result_d = pack_fp(sign_q, exp_fast[7:0], sum_fast[MANT_W-2 -: 23]);
          end
`else
          // A shift that would drive the exponent to 0 underflows: flush instead.
          if (exp_q <= EXP_W'(1)) begin
            sum_d    = '0;
            exp_d    = '0;
            result_d = pack_fp(sign_q, 8'd0, 23'd0);
            state_d  = DONE;
          end else begin
            sum_d = sum_q << 1;
            exp_d = exp_dec;
          end
`endif
        end
      end
      DONE: begin
        if (bus.outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.inReady  = (state_q == IDLE);
  assign bus.outValid = (state_q == DONE);
  assign bus.result   = result_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_fp_add_normalize.sv
// Directed-vector bench for fp_add_normalize: results, latency, back-pressure and mid-op reset.
module tb_fp_add_normalize;
  import fp_pkg::*;

  logic   clk = 1'b0;
  logic   reset;
  state_t dbg_state;
  int     n_vec = 0;
  int     n_err = 0;

  fp_add_normalize_if #(.EXP_W(8), .MANT_W(24)) bus ();

  fp_add_normalize #(.EXP_W(8), .MANT_W(24)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

`ifdef FAST_NORM_EN
  localparam int LAT_SUB1 = 3;
  localparam int LAT_UNDERFLOW = 3;
  localparam int LAT_ONE_SHIFT = 3;
`else
  localparam int LAT_SUB1 = 26;
  localparam int LAT_UNDERFLOW = 4;
  localparam int LAT_ONE_SHIFT = 4;
`endif

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    if (observed !== expected) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic scramble_inputs();
    bus.signA            = 1'($urandom_range(0, 1));
    bus.signB            = 1'($urandom_range(0, 1));
    bus.exponentIn       = 8'($urandom_range(0, 255));
    bus.alignedMantissaA = 24'($urandom_range(0, 24'hFFFFFF));
    bus.alignedMantissaB = 24'($urandom_range(0, 24'hFFFFFF));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (!bus.inReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.inReady) check_val({tag, "_idle_timeout"}, 32'(bus.inReady), 32'd1);
  endtask

  // Latency is the index of the first clock interval after the accept edge
  // (interval 1 directly follows it) in which outValid is high.
  task automatic run_op(input string tag, input logic sa, input logic sb, input logic [7:0] e,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input logic [31:0] exp_res, input int exp_lat, input int hold);
    int          lat;
    bit          seen;
    logic [31:0] held;
    wait_idle(tag);
    bus.signA            = sa;
    bus.signB            = sb;
    bus.exponentIn       = e;
    bus.alignedMantissaA = ma;
    bus.alignedMantissaB = mb;
    bus.inValid          = 1'b1;
    @(posedge clk);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        bus.inValid = 1'b0;
        scramble_inputs();
      end
      seen = bus.outValid;
    end
    if (!seen) begin
      check_val({tag, "_outvalid_timeout"}, 32'(bus.outValid), 32'd1);
    end else begin
      if (exp_lat > 0) check_val({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      check_val({tag, "_result"}, bus.result, exp_res);
      held = exp_res;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        check_val({tag, "_hold_result"}, bus.result, held);
        check_val({tag, "_hold_flags"}, {30'd0, bus.outValid, bus.inReady}, 32'b10);
      end
      bus.outReady = 1'b1;
      @(negedge clk);
      bus.outReady = 1'b0;
      check_val({tag, "_back_idle"}, {30'd0, bus.outValid, bus.inReady}, 32'b01);
    end
  endtask

  initial begin
    bus.inValid  = 1'b0;
    bus.outReady = 1'b0;
    scramble_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("reset_inready", 32'(bus.inReady), 32'd1);
    check_val("reset_outvalid", 32'(bus.outValid), 32'd0);
    check_val("reset_result", bus.result, 32'd0);
    check_val("reset_state", 32'(dbg_state), 32'(IDLE));

    run_op("one_plus_one",   1'b0, 1'b0, 8'(FP_BIAS), 24'h800000, 24'h800000, 32'h40000000, 3, 0);
    run_op("one_minus_one",  1'b0, 1'b1, 8'(FP_BIAS), 24'h800000, 24'h800000, 32'h00000000, 0, 0);
    run_op("sub_to_ulp",     1'b0, 1'b1, 8'(FP_BIAS), 24'h800000, 24'h7FFFFF, 32'h34000000, LAT_SUB1, 0);
    run_op("overflow_inf",   1'b0, 1'b0, 8'hFE,       24'h800000, 24'h800000, 32'h7F800000, 3, 0);
    run_op("b_larger_neg",   1'b0, 1'b1, 8'h80,       24'h800000, 24'hC00000, 32'hBF800000, LAT_ONE_SHIFT, 0);
    run_op("neg_add",        1'b1, 1'b1, 8'(FP_BIAS), 24'hC00000, 24'hA00000, 32'hC0300000, 3, 0);
    run_op("underflow_neg0", 1'b1, 1'b0, 8'h02,       24'h800000, 24'h7FFFFF, 32'h80000000, LAT_UNDERFLOW, 0);
    run_op("truncate",       1'b0, 1'b0, 8'(FP_BIAS), 24'h800003, 24'h800000, 32'h40000001, 3, 0);
    run_op("backpressure",   1'b0, 1'b0, 8'(FP_BIAS), 24'h800000, 24'h800000, 32'h40000000, 3, 5);

    // Reset in interval 2 after accept, while the subtraction is in NORM.
    wait_idle("midreset");
    bus.signA            = 1'b0;
    bus.signB            = 1'b1;
    bus.exponentIn       = 8'(FP_BIAS);
    bus.alignedMantissaA = 24'h800000;
    bus.alignedMantissaB = 24'h7FFFFF;
    bus.inValid          = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.inValid = 1'b0;
    @(negedge clk);
    check_val("midreset_in_norm", 32'(dbg_state), 32'(NORM));
    reset = 1'b1;
    #1;
    check_val("midreset_outvalid", 32'(bus.outValid), 32'd0);
    check_val("midreset_result", bus.result, 32'd0);
    check_val("midreset_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("midreset_inready", 32'(bus.inReady), 32'd1);

    run_op("after_reset",    1'b0, 1'b0, 8'(FP_BIAS), 24'h800000, 24'h800000, 32'h40000000, 3, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
